// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Widths, FSM encodings and the queued {pc, inst} entry.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched {pc, inst} pairs.
// Flush wins over push and pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM address and
// feeds decode from a small {pc, inst} queue.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  output logic [31:0]       fetch_cnt
);

  logic [1:0]              state;
  logic [ADDR_W-1:0]       pc;
  logic                    redir;
  logic                    pop;
  logic                    push;
  logic                    q_full;
  logic                    q_empty;
  logic [$clog2(DEPTH):0]  q_count_unused;
  fetch_entry_t            q_din;
  fetch_entry_t            q_head;

  assign rom_addr  = pc;
  assign out_valid = ~q_empty;
  assign out_pc    = q_head.pc;
  assign out_inst  = q_head.inst;

  // Redirects only count once the first fetch slot exists
  assign redir = redirect_valid & (state != ST_BOOT);
  assign pop   = out_valid & out_ready;
  assign push  = (state == ST_RUN) & ~halt & ~redirect_valid
               & (~q_full | pop);

  assign q_din.pc   = pc;
  assign q_din.inst = rom_inst;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (q_din),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else if (redir) begin
      pc <= {redirect_target[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      pc        <= pc + ADDR_W'(4);
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (halt) state <= ST_HALT;
        ST_HALT: if (!halt) state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
